duty_pattern_gen: RTL and testbench
===================================

Name: duty_pattern_gen

Overview:
- Multi-channel, parametrised thermometer-duty serial pattern generator.
- A shared free-running period counter drives NUM_CH channels. Each channel outputs a high for the first `duty` cycles of every 2^CNT_W-cycle period.
- Duty values are loaded per channel through a valid/ready config port and applied glitch-free at period boundaries.
- Sits between the control/config logic and the output pins, as the successor of the 8-slot pattern-memory/counter/mux path.

Parameters:
- CNT_W, 3: period counter width; period P = 2^CNT_W cycles (legal 1..16).
- NUM_CH, 4: number of output channels (legal 1..32).
- CH_W, $clog2(NUM_CH) min 1: channel-select width (derived, localparam).

Ports:
- clk  in  1  rising-edge clock
- clear_n  in  1  asynchronous active-low reset
- enable  in  1  run; low holds counter at 0 and forces outputs low
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted when high with cfg_valid
- cfg_ch  in  CH_W  target channel
- cfg_duty  in  CNT_W+1  requested duty, in cycles (0..P)
- out  out  NUM_CH  per-channel pattern bits, registered
- period_end  out  1  one-cycle pulse in the last cycle of each period (ctr==P-1, enable high)
- ctr  out  CNT_W  current period count, for debug/monitor

Behaviour:
- Reset (clear_n low, async):
  - ctr=0, out=0, period_end=0.
  - All active and shadow duties = 0, all pending flags = 0, cfg_ready=1.
- Counter:
  - On each edge with enable=1: ctr <= ctr+1, wrapping P-1 -> 0.
  - With enable=0: ctr <= 0.
- Output:
  - out[i] is registered and equals (ctr < duty_act[i]) for the ctr value it is presented with; out and ctr change on the same edge.
  - Duty 0 gives a constant 0; duty P gives a constant 1.
  - Duty d gives exactly d high cycles per period, starting at ctr==0.
  - enable=0 gives out=0 from the next edge.
- Duty arithmetic:
  - cfg_duty > P saturates to P at capture.
  - The comparison is unsigned, CNT_W+1 bits wide.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] (combinational from cfg_ch).
  - Transfer occurs on an edge with cfg_valid && cfg_ready: shadow[cfg_ch] <= saturated duty, pending[cfg_ch] <= 1.
  - cfg_ch >= NUM_CH: cfg_ready=1 and the write is silently dropped.
- Commit:
  - On the wrap edge (ctr==P-1, enable=1), every channel with pending=1 copies shadow to active and clears pending.
  - The new duty is therefore first visible at the ctr==0 output cycle.
  - With enable=0, pending channels commit on every edge (immediate apply while stopped).
- Simultaneous write and wrap:
  - A write accepted on the wrap edge sets pending and is not committed on that edge.
  - It applies at the following wrap.
  - A channel already pending has cfg_ready=0, so no write is lost.
- Reset mid-period: everything returns to reset values immediately; uncommitted shadows are discarded.
- enable falling mid-period:
  - Next edge gives ctr=0, out=0, period_end=0.
  - On enable rising, the period restarts at ctr=0 with out reflecting the active duties on the first enabled edge.

Optional Feature:
- Macro: DUTY_PATTERN_GEN_PHASE_STAGGER_EN.
- Defined:
  - Channel i compares (ctr + i*(P/NUM_CH)) mod P against its duty, spreading rising edges evenly.
  - Requires NUM_CH a power of 2 with NUM_CH <= P; otherwise the offset is i mod P.
  - Commit timing is still tied to the global wrap.
- Undefined: all channels are phase-aligned at ctr==0.

Decomposition:
- Package duty_pattern_pkg holds:
  - Default CNT_W and NUM_CH.
  - Function clog2_min1.
  - Function sat_duty (saturate to P).
- Sub-module duty_pattern_ch, one per channel via generate. Each instance holds the channel's shadow, active and pending registers plus its compare/out register.
- Top keeps the counter, period_end, cfg decode/ready mux and the commit strobe.

Test Plan (CNT_W=3, NUM_CH=4, P=8):
- Reset then enable=1, no config -> out=4'b0000 for 16 cycles; period_end pulses at ctr=7 each period.
- Write ch0 duty=3 mid-period -> cfg_ready for ch0 goes low next cycle. From the next ctr==0, out[0] is high for ctr 0..2 and low for 3..7. cfg_ready returns high after the wrap.
- Write ch1 duty=8 and ch2 duty=15 -> both capture 8. out[1]=out[2]=1 continuously after the commit.
- Write ch3 duty=5 on the exact wrap edge -> not applied at ctr 0 of that period; applied one period later. A second write to ch3 is stalled (cfg_ready=0) until then.
- Assert clear_n=0 at ctr=4 with ch0 pending -> out=0, ctr=0, cfg_ready=1 immediately. After release, ch0 keeps duty 0.
- Drop enable for 3 cycles with a pending write -> out=0, ctr=0, write commits while stopped. On re-enable, the new duty is visible from ctr=0.
- With DUTY_PATTERN_GEN_PHASE_STAGGER_EN, all duties=2 -> out[i] high when ctr is in {(8-2i) mod 8, (9-2i) mod 8}.

Source files
------------

// File: rtl/duty_pattern_pkg.sv
// Shared constants and helpers for the duty_pattern_gen slice: defaults,
// channel-select width, duty saturation and the per-channel phase offset.
package duty_pattern_pkg;

    localparam int DEFAULT_CNT_W  = 3;
    localparam int DEFAULT_NUM_CH = 4;
    localparam int DUTY_MAX_W     = 17;  // wide enough for P = 2^16

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Clamp a requested duty to the period length P = 2^cnt_w.
    function automatic logic [DUTY_MAX_W-1:0] sat_duty(input logic [DUTY_MAX_W-1:0] duty,
                                                       input int cnt_w);
        logic [DUTY_MAX_W-1:0] p;
        p = DUTY_MAX_W'(1) << cnt_w;
        return (duty > p) ? p : duty;
    endfunction

    // Even spread when NUM_CH is a power of two no larger than P, else i mod P.
    function automatic int stagger_offset(input int ch, input int num_ch, input int cnt_w);
        int p;
        p = 1 << cnt_w;
        if (((num_ch & (num_ch - 1)) == 0) && (num_ch <= p))
            return ch * (p / num_ch);
        return ch % p;
    endfunction

endpackage

// File: rtl/duty_pattern_gen_if.sv
// Config port of duty_pattern_gen: valid/ready write of one channel's duty.
interface duty_pattern_gen_if
    import duty_pattern_pkg::*;
#(
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int NUM_CH = DEFAULT_NUM_CH
);
    localparam int CH_W = clog2_min1(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W:0]   cfg_duty;

    modport master (output cfg_valid, cfg_ch, cfg_duty, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_duty, output cfg_ready);

endinterface

// File: rtl/duty_pattern_ch.sv
// One output channel: shadow/active duty with pending flag, and the registered
// thermometer compare against the (optionally offset) next period count.
module duty_pattern_ch
    import duty_pattern_pkg::*;
#(
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int OFFSET = 0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             enable,
    input  logic             commit,
    input  logic             wr_en,
    input  logic [CNT_W:0]   wr_duty,
    input  logic [CNT_W-1:0] ctr_next,
    output logic             pending,
    output logic             out
);
    localparam logic [CNT_W-1:0] PHASE_OFF = CNT_W'(OFFSET);

    logic [CNT_W:0]   shadow;
    logic [CNT_W:0]   active;
    logic [CNT_W:0]   active_next;
    logic [CNT_W-1:0] phase_next;

    // The output for the next cycle must already see a duty committed on this edge.
    assign active_next = (commit && pending) ? shadow : active;
    assign phase_next  = ctr_next + PHASE_OFF;  // natural wrap gives mod P

    // NOTE: shadow/active are cleared by reset too: a discarded shadow or a
    // stale active duty would be visible on the pins after clear_n.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            out     <= 1'b0;
        end else begin
            active <= active_next;
            if (commit && pending)
                pending <= 1'b0;
            // wr_en implies pending was clear, so it never races the commit.
            if (wr_en) begin
                shadow  <= wr_duty;
                pending <= 1'b1;
            end
            out <= enable && ({1'b0, phase_next} < active_next);
        end
    end

endmodule

// File: rtl/duty_pattern_gen.sv
// Multi-channel thermometer-duty pattern generator (shared period counter).
// Optional macro DUTY_PATTERN_GEN_PHASE_STAGGER_EN staggers channel phases.
module duty_pattern_gen
    import duty_pattern_pkg::*;
#(
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int NUM_CH = DEFAULT_NUM_CH
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              enable,
    duty_pattern_gen_if.slave cfg,
    output logic [NUM_CH-1:0] out,
    output logic              period_end,
    output logic [CNT_W-1:0]  ctr
);
    localparam int               CH_W     = clog2_min1(NUM_CH);
    localparam logic [CNT_W-1:0] CTR_LAST = '1;

    logic [CNT_W-1:0]  ctr_next;
    logic              wrap;
    logic              commit;
    logic              wr_go;
    logic [CNT_W:0]    duty_sat;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_en;

    assign wrap       = enable && (ctr == CTR_LAST);
    assign commit     = wrap || !enable;  // stopped: apply pending duties at once
    assign ctr_next   = enable ? ctr + 1'b1 : '0;
    assign period_end = wrap;
    assign duty_sat   = (CNT_W+1)'(sat_duty(DUTY_MAX_W'(cfg.cfg_duty), CNT_W));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            ctr <= '0;
        else
            ctr <= ctr_next;
    end

    // Unmatched channel codes keep ready high and enable no write.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the loops can leave a latch behind.
        cfg.cfg_ready = 1'b1;
        wr_en         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i))
                cfg.cfg_ready = !pending[i];
        end
        wr_go = cfg.cfg_valid && cfg.cfg_ready;
        for (int i = 0; i < NUM_CH; i++)
            wr_en[i] = wr_go && (cfg.cfg_ch == CH_W'(i));
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
`ifdef DUTY_PATTERN_GEN_PHASE_STAGGER_EN
        localparam int OFFSET = stagger_offset(g, NUM_CH, CNT_W);
`else
        localparam int OFFSET = 0;
`endif
        duty_pattern_ch #(
            .CNT_W  (CNT_W),
            .OFFSET (OFFSET)
        ) u_ch (
            .clk      (clk),
            .clear_n  (clear_n),
            .enable   (enable),
            .commit   (commit),
            .wr_en    (wr_en[g]),
            .wr_duty  (duty_sat),
            .ctr_next (ctr_next),
            .pending  (pending[g]),
            .out      (out[g])
        );
    end

endmodule

// File: tb/tb_duty_pattern_gen.sv
// Scoreboard bench for duty_pattern_gen: a period-level reference model pushes
// expected per-cycle outputs; a negedge monitor pops and compares them.
module tb_duty_pattern_gen;

    localparam int CNT_W  = 3;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int P      = 1 << CNT_W;

    typedef struct {
        int                ctr;
        logic [NUM_CH-1:0] out;
        logic              pe;
        logic              rdy;
    } exp_t;

    logic              clk = 1'b0;
    logic              clear_n;
    logic              enable;
    logic [NUM_CH-1:0] out;
    logic              period_end;
    logic [CNT_W-1:0]  ctr;

    duty_pattern_gen_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) cfg_if ();

    duty_pattern_gen #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .enable     (enable),
        .cfg        (cfg_if.slave),
        .out        (out),
        .period_end (period_end),
        .ctr        (ctr)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: period position and per-channel duty bookkeeping.
    int m_ctr;
    int m_act[NUM_CH];
    int m_shadow[NUM_CH];
    bit m_pend[NUM_CH];
    bit m_outen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int ch_off(input int i);
`ifdef DUTY_PATTERN_GEN_PHASE_STAGGER_EN
        if (((NUM_CH & (NUM_CH - 1)) == 0) && (NUM_CH <= P))
            return i * (P / NUM_CH);
        return i % P;
`else
        return 0 * i;
`endif
    endfunction

    function automatic void model_reset();
        m_ctr   = 0;
        m_outen = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_act[i]    = 0;
            m_shadow[i] = 0;
            m_pend[i]   = 0;
        end
    endfunction

    // One clock edge under the inputs that were held during the past cycle.
    function automatic void model_edge();
        bit en, commit, acc;
        int ch, duty;
        if (clear_n !== 1'b1)
            return;
        en     = enable;
        commit = !en || (m_ctr == P - 1);
        ch     = int'(cfg_if.cfg_ch);
        duty   = int'(cfg_if.cfg_duty);
        acc    = cfg_if.cfg_valid && (ch >= NUM_CH || !m_pend[ch]);
        for (int i = 0; i < NUM_CH; i++) begin
            if (commit && m_pend[i]) begin
                m_act[i]  = m_shadow[i];
                m_pend[i] = 0;
            end
        end
        if (acc && ch < NUM_CH) begin
            m_shadow[ch] = (duty > P) ? P : duty;
            m_pend[ch]   = 1;
        end
        m_ctr   = en ? (m_ctr + 1) % P : 0;
        m_outen = en;
    endfunction

    function automatic void push_expect();
        exp_t e;
        int   ch;
        ch    = int'(cfg_if.cfg_ch);
        e.ctr = m_ctr;
        e.pe  = enable && (m_ctr == P - 1);
        e.rdy = (ch >= NUM_CH) || !m_pend[ch];
        for (int i = 0; i < NUM_CH; i++)
            e.out[i] = m_outen && (((m_ctr + ch_off(i)) % P) < m_act[i]);
        sb_q.push_back(e);
    endfunction

    int last_ch = 0;

    task automatic step(input bit clr_n_i, input bit en_i, input bit v_i,
                        input int ch_i, input int d_i);
        @(posedge clk);
        #1;
        model_edge();
        clear_n          = clr_n_i;
        enable           = en_i;
        cfg_if.cfg_valid = v_i;
        cfg_if.cfg_ch    = CH_W'(ch_i);
        cfg_if.cfg_duty  = (CNT_W+1)'(d_i);
        last_ch          = ch_i;
        if (!clr_n_i)
            model_reset();
        push_expect();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1, 1, 0, last_ch, 0);
    endtask

    // Advance until the model sits at count c (bounded to two periods).
    task automatic run_until(input int c);
        for (int k = 0; k < 2 * P && m_ctr != c; k++)
            idle(1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("ctr",        32'(ctr),              32'(e.ctr));
                check("out",        32'(out),              32'(e.out));
                check("period_end", 32'(period_end),       32'(e.pe));
                check("cfg_ready",  32'(cfg_if.cfg_ready), 32'(e.rdy));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        clear_n          = 1'b0;
        enable           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_duty  = '0;
        model_reset();

        // Reset, then free run with no config.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle(16);

        // ch0 duty 3 written mid-period.
        run_until(2);
        step(1, 1, 1, 0, 3);
        idle(20);

        // Full-period duty and saturation of an oversized request.
        step(1, 1, 1, 1, 8);
        step(1, 1, 1, 2, 15);
        idle(20);

        // Write presented in the ctr==P-1 cycle, then a second write held
        // until the channel frees up.
        run_until(6);
        step(1, 1, 1, 3, 5);
        for (int k = 0; k < 12; k++)
            step(1, 1, 1, 3, 1);
        idle(20);

        // Reset mid-period with ch0 pending.
        run_until(2);
        step(1, 1, 1, 0, 6);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(20);

        // Pending write that commits while stopped.
        run_until(1);
        step(1, 1, 1, 2, 4);
        for (int k = 0; k < 3; k++)
            step(1, 0, 0, 2, 0);
        idle(20);

        // All channels at duty 2 (shows the stagger pattern when enabled).
        for (int i = 0; i < NUM_CH; i++)
            step(1, 1, 1, i, 2);
        idle(3 * P);

        // Randomised traffic.
        for (int k = 0; k < 2000; k++)
            step(($urandom_range(199) != 0), ($urandom_range(15) != 0),
                 1'($urandom_range(1)), $urandom_range(NUM_CH - 1), $urandom_range(15));
        idle(4);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
